// File: rtl/clk_enable_pkg.sv
// Shared types for the clock-enable generator: lock-qualification FSM states
// and the helper that sizes the configuration channel index.
package clk_enable_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // A single-channel build still needs a 1-bit index so out-of-range selects exist.
  function automatic int chan_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/ce_accum.sv
// One fractional-rate enable channel: phase accumulator whose carry becomes a one-cycle strobe.
// Strobe registered one cycle after the carrying add; config load is always accepted, no backpressure.
module ce_accum #(
  parameter int                 ACC_W   = 24,
  parameter logic [ACC_W-1:0]   DEF_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             realign,
  input  logic             run,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [ACC_W-1:0] cfg_phase,
  output logic             ce
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      inc   <= DEF_INC;
      phase <= '0;
      acc   <= '0;
      ce    <= 1'b0;
    end else begin
      if (load) begin
        inc   <= cfg_inc;
        phase <= cfg_phase;
      end
      // Realign wins over accumulation so the new phase lands exactly one cycle after accept.
      if (realign) begin
        acc <= cfg_phase;
        ce  <= 1'b0;
      end else if (run) begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end else begin
        acc <= phase;
        ce  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator gated by a synchronised, settled PLL lock.
// locked rises 3+SETTLE_CYCLES cycles after steady lock; cfg_ready drops for one cycle after each accept.
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int                          CHANNELS      = 3,
  parameter int                          ACC_W         = 24,
  parameter int                          SETTLE_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0]   DEF_INC       = '0
) (
  input  logic                              refclk,
  input  logic                              rst,
  input  logic                              pll_locked,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [chan_idx_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]                  cfg_inc,
  input  logic [ACC_W-1:0]                  cfg_phase,
  output logic [CHANNELS-1:0]               ce,
  output logic                              locked
);

  localparam int          CHAN_W      = chan_idx_w(CHANNELS);
  localparam int          CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  logic             lk_s1;
  logic             lk_s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_done;
  logic             cfg_accept;
  logic             in_run;
  logic             run_en;
  logic [CHANNELS-1:0] chan_load;

  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_s1 <= 1'b0;
      lk_s2 <= 1'b0;
    end else begin
      lk_s1 <= pll_locked;
      lk_s2 <= lk_s1;
    end
  end

  assign settle_done = (settle_cnt == CNT_W'(SETTLE_LAST));

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= ST_WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_LOCK: if (lk_s2) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!lk_s2) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (settle_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:       if (!lk_s2) state_nxt = ST_WAIT_LOCK;
      default:      state_nxt = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst || state != ST_SETTLE) begin
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  assign cfg_accept = cfg_valid & cfg_ready;

  always_ff @(posedge refclk) begin
    if (rst) begin
      cfg_ready <= 1'b1;
    end else begin
      cfg_ready <= ~cfg_accept;
    end
  end

  assign in_run = (state == ST_RUN);
  assign locked = in_run;
  // Stop accumulating in the last RUN cycle so no strobe escapes after lk_s2 has dropped.
  assign run_en = in_run & lk_s2;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan_load[i] = cfg_accept && (cfg_chan == CHAN_W'(i));

    ce_accum #(
      .ACC_W   (ACC_W),
      .DEF_INC (DEF_INC[i*ACC_W +: ACC_W])
    ) u_ce_accum (
      .clk       (refclk),
      .rst       (rst),
      .load      (chan_load[i]),
      .realign   (chan_load[i] & in_run),
      .run       (run_en),
      .cfg_inc   (cfg_inc),
      .cfg_phase (cfg_phase),
      .ce        (ce[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: stimulus queues expected strobe/lock events by absolute
// cycle, a negedge monitor pops and compares whenever ce is non-zero or locked changes.
module tb_clk_enable_gen;

  localparam int CH = 3;
  localparam int AW = 8;
  localparam int SC = 16;

  logic          refclk     = 1'b0;
  logic          rst        = 1'b1;
  logic          pll_locked = 1'b1;
  logic          cfg_valid  = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan   = 2'd0;
  logic [AW-1:0] cfg_inc    = '0;
  logic [AW-1:0] cfg_phase  = '0;
  logic [CH-1:0] ce;
  logic          locked;

  clk_enable_gen #(
    .CHANNELS      (CH),
    .ACC_W         (AW),
    .SETTLE_CYCLES (SC),
    .DEF_INC       (24'h0)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_inc    (cfg_inc),
    .cfg_phase  (cfg_phase),
    .ce         (ce),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [CH-1:0] ce;
    logic          lk;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_on  = 1'b0;
  logic prev_lk = 1'b0;

  // Hand-computed strobe offsets after RUN entry.
  // Rates: ch0 inc=64 fires every 4th; ch1 inc=96 fires at 3,6,8 of every 8.
  int            rate_ofs [8] = '{3, 4, 6, 8, 11, 12, 14, 16};
  logic [CH-1:0] rate_ce  [8] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b010, 3'b001, 3'b010, 3'b011};
  // Phase: ch0 inc=64 ph=0, ch1 inc=64 ph=128; ch0 realigned to ph=128 at +11 (its +12 strobe vanishes).
  int            ph_ofs   [6] = '{2, 4, 6, 8, 10, 14};
  logic [CH-1:0] ph_ce    [6] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b011};
  logic          hs_pat   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [CH-1:0] c, input logic l);
    ev_t e;
    e.at = at;
    e.ce = c;
    e.lk = l;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic cfg_pulse(input logic [1:0] ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_inc   = inc;
    cfg_phase = ph;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  always @(negedge refclk) begin
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: nothing at cycle %0d, expected ce=%b locked=%b",
                 exp_q[0].at, exp_q[0].ce, exp_q[0].lk);
        void'(exp_q.pop_front());
      end
      if (ce !== '0 || locked !== prev_lk) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cycle %0d ce=%b locked=%b, expected no event", cyc, ce, locked);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.at != cyc || mon_e.ce !== ce || mon_e.lk !== locked) begin
            n_fail++;
            $display("FAIL event: got cycle %0d ce=%b locked=%b, expected cycle %0d ce=%b locked=%b",
                     cyc, ce, locked, mon_e.at, mon_e.ce, mon_e.lk);
          end
        end
      end
      prev_lk <= locked;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not reach its end by cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, lk_drop, r, t2, t3, n_acc;

    tick(4);
    mon_on = 1'b1;
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_ce", 32'(ce), 32'd0);
    check("reset_ready", 32'(cfg_ready), 32'd1);

    // Bring-up with rates programmed while still qualifying lock.
    t0  = cyc;
    rst = 1'b0;
    expect_ev(t0 + 19, 3'b000, 1'b1);
    for (int i = 0; i < 8; i++) expect_ev(t0 + 19 + rate_ofs[i], rate_ce[i], 1'b1);
    cfg_pulse(2'd0, 8'd64, 8'd0);
    check("ready_after_accept", 32'(cfg_ready), 32'd0);
    tick(1);
    cfg_pulse(2'd1, 8'd96, 8'd0);

    // Lock loss for 5 cycles, reprogram phases while out of RUN.
    wait_to(t0 + 35);
    lk_drop    = cyc;
    pll_locked = 1'b0;
    expect_ev(lk_drop + 3, 3'b000, 1'b0);
    wait_to(lk_drop + 3);
    cfg_pulse(2'd0, 8'd64, 8'd0);
    wait_to(lk_drop + 5);
    pll_locked = 1'b1;
    r = lk_drop + 24;
    expect_ev(r, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) expect_ev(r + ph_ofs[i], ph_ce[i], 1'b1);
    cfg_pulse(2'd1, 8'd64, 8'd128);

    // Held request to an out-of-range channel in RUN.
    wait_to(r + 5);
    n_acc     = 0;
    cfg_valid = 1'b1;
    cfg_chan  = 2'd3;
    cfg_inc   = 8'hff;
    cfg_phase = 8'h40;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hs_ready_%0d", i), 32'(cfg_ready), 32'(hs_pat[i]));
      if (cfg_ready) n_acc++;
      tick(1);
    end
    cfg_valid = 1'b0;
    check("hs_accepts", 32'(n_acc), 32'd2);

    // Realign ch0 in RUN.
    wait_to(r + 11);
    cfg_pulse(2'd0, 8'd64, 8'd128);

    // Reset in RUN.
    wait_to(r + 16);
    rst = 1'b1;
    expect_ev(r + 17, 3'b000, 1'b0);
    tick(1);
    rst = 1'b0;
    t2  = cyc;
    check("run_rst_locked", 32'(locked), 32'd0);
    check("run_rst_ce", 32'(ce), 32'd0);
    check("run_rst_ready", 32'(cfg_ready), 32'd1);

    // Reset in SETTLE, then a full bring-up with increments back at zero.
    wait_to(t2 + 10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    t3  = cyc;
    check("settle_rst_locked", 32'(locked), 32'd0);
    check("settle_rst_ce", 32'(ce), 32'd0);
    check("settle_rst_ready", 32'(cfg_ready), 32'd1);
    expect_ev(t3 + 19, 3'b000, 1'b1);

    wait_to(t3 + 19 + 30);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
